pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYC, default 5: busy cycles of the mult/multu unit.
REQ-002 SHALL have parameter DIV_CYC, default 10: busy cycles of the div/divu unit.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 IntReq  in  1  interrupt/exception request; flushes the pipeline.
REQ-006 rs_D, rt_D  in  5 each  source register numbers of the instruction in D.
REQ-007 tuse_rs, tuse_rt  in  2 each  cycles until the D instruction needs rs/rt; 3 = unused.
REQ-008 A3_E, A3_M  in  5 each  destination registers in E and M; 0 = none.
REQ-009 tnew_E, tnew_M  in  2 each  cycles until the E/M results are forwardable.
REQ-010 md_use_D  in  1  the D instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-011 md_start_E, md_is_div_E  in  1 each  E issues a mult or div this cycle; 1 = div.
REQ-012 en_PC, en_D  out  1 each  write enables for the PC and regD.
REQ-013 clr_D, clr_E, clr_M, clr_W  out  1 each  synchronous clears for regD/regE/regM/regW.
REQ-014 md_busy  out  1  the mult/div unit is occupied.
REQ-015 stall_cnt  out  32  number of cycles with stall asserted since reset.

Function
REQ-016 rs hazard SHALL be (rs_D!=0) and ((rs_D==A3_E and tnew_E>tuse_rs) or (rs_D==A3_M and tnew_M>tuse_rs)); the rt hazard SHALL be the same with rt_D/tuse_rt.
REQ-017 md hazard SHALL be md_use_D and (md_busy or md_start_E).
REQ-018 stall SHALL be (rs hazard or rt hazard or md hazard) and not IntReq.
REQ-019 On stall: en_PC=0, en_D=0, clr_E=1, clr_D=clr_M=clr_W=0, all in the same cycle (combinational).
REQ-020 With no stall and no IntReq: en_PC=en_D=1 and all clr_*=0.
REQ-021 On IntReq: clr_D=clr_E=clr_M=clr_W=1 and en_PC=1 (the PC loads the handler address); IntReq overrides stall.
REQ-022 The md unit SHALL be a two-state FSM: IDLE (cnt==0) and BUSY (cnt!=0); md_busy = (cnt!=0), driven from a register.
REQ-023 md_start_E in cycle t, with IntReq=0, SHALL load cnt with MULT_CYC or DIV_CYC, so that md_busy is high for exactly that many cycles starting at t+1.
REQ-024 In BUSY, cnt SHALL decrement by 1 per cycle; reaching 0 SHALL return the FSM to IDLE, with no wrap below 0.
REQ-025 md_start_E in the same cycle as IntReq SHALL be ignored, because the instruction is being flushed.
REQ-026 IntReq while BUSY SHALL NOT cancel the counter; the operation in flight completes.
REQ-027 md_start_E while BUSY SHALL reload cnt with the new count; the new value takes priority over the decrement.
REQ-028 stall_cnt SHALL increment in every cycle where stall=1 and SHALL saturate at 32'hFFFFFFFF.
REQ-029 Counter width SHALL be ceil(log2(max(MULT_CYC,DIV_CYC)+1)) bits, using unsigned arithmetic.

Reset
REQ-030 While reset=1 at the clock edge: cnt=0 (IDLE), md_busy=0, stall_cnt=0.
REQ-031 While reset=1: clr_D=clr_E=clr_M=clr_W=1 and en_PC=en_D=1, independent of the other inputs.
REQ-032 Reset asserted mid-operation SHALL abandon any md operation immediately, with md_busy=0 in the next cycle.

Configuration
REQ-033 Macro MD_UNIT_EN defined: the md FSM, md hazard and md_busy behave as specified above.
REQ-034 Macro MD_UNIT_EN undefined: the counter is removed, md_busy is tied to 0, the md hazard is 0, and md_use_D/md_start_E/md_is_div_E are ignored.

Verification
REQ-035 rs_D=5, tuse_rs=0, A3_E=5, tnew_E=1 -> en_PC=0, en_D=0, clr_E=1, stall_cnt increments by 1.
REQ-036 rs_D=0, A3_E=0, tnew_E=2, tuse_rs=0 -> no stall: en_PC=1, clr_E=0.
REQ-037 md_start_E=1, md_is_div_E=1 at t; md_use_D=1 from t -> md_busy high t+1..t+10; stall in t..t+10; released at t+11.
REQ-038 IntReq=1 while rt hazard is active -> all clr_*=1, en_PC=1, stall_cnt unchanged.
REQ-039 md_start_E=1 (mult) with IntReq=1 -> md_busy stays 0; mult started at t, IntReq at t+2 -> md_busy still high through t+5.
REQ-040 Reset at t+3 during a div -> md_busy=0 and stall_cnt=0 at t+4; with MD_UNIT_EN undefined, REQ-037 stimulus -> md_busy=0, no stall.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush control with mult/div busy tracking (optional MD_UNIT_EN)
// MD_UNIT_EN defined: mult/div busy counter and md hazard; undefined: md_busy tied low.
module pipe_hazard_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IntReq,
    input  logic [4:0]  rs_D,
    input  logic [4:0]  rt_D,
    input  logic [1:0]  tuse_rs,
    input  logic [1:0]  tuse_rt,
    input  logic [4:0]  A3_E,
    input  logic [4:0]  A3_M,
    input  logic [1:0]  tnew_E,
    input  logic [1:0]  tnew_M,
    input  logic        md_use_D,
    input  logic        md_start_E,
    input  logic        md_is_div_E,
    output logic        en_PC,
    output logic        en_D,
    output logic        clr_D,
    output logic        clr_E,
    output logic        clr_M,
    output logic        clr_W,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    logic hazard_rs;
    logic hazard_rt;
    logic hazard_md;
    logic stall;

    always_comb begin
        hazard_rs = (rs_D != 5'd0) &&
                    (((rs_D == A3_E) && (tnew_E > tuse_rs)) ||
                     ((rs_D == A3_M) && (tnew_M > tuse_rs)));
        hazard_rt = (rt_D != 5'd0) &&
                    (((rt_D == A3_E) && (tnew_E > tuse_rt)) ||
                     ((rt_D == A3_M) && (tnew_M > tuse_rt)));
        stall     = (hazard_rs || hazard_rt || hazard_md) && !IntReq;
    end

`ifdef MD_UNIT_EN
    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    md_state_t     md_state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] md_load;
    logic          busy_q;

    assign md_load = md_is_div_E ? CW'(DIV_CYC) : CW'(MULT_CYC);

    // A start from a flushed E instruction is dropped; a live start overrides the decrement.
    always_ff @(posedge clk) begin
        if (reset) begin
            md_state <= MD_IDLE;
            cnt      <= '0;
            busy_q   <= 1'b0;
        end else if (md_start_E && !IntReq) begin
            cnt      <= md_load;
            md_state <= (md_load != '0) ? MD_BUSY : MD_IDLE;
            busy_q   <= (md_load != '0);
        end else if (md_state == MD_BUSY) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                md_state <= MD_IDLE;
                busy_q   <= 1'b0;
            end
        end
    end

    assign md_busy   = busy_q;
    assign hazard_md = md_use_D && (busy_q || md_start_E);
`else
    logic unused_md_inputs;

    assign unused_md_inputs = ^{md_use_D, md_start_E, md_is_div_E};
    assign md_busy          = 1'b0;
    assign hazard_md        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= 32'd0;
        end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    // Reset and interrupt both flush every stage; the PC still loads (reset/handler vector).
    always_comb begin
        en_PC = 1'b1;
        en_D  = 1'b1;
        clr_D = 1'b0;
        clr_E = 1'b0;
        clr_M = 1'b0;
        clr_W = 1'b0;
        if (reset || IntReq) begin
            clr_D = 1'b1;
            clr_E = 1'b1;
            clr_M = 1'b1;
            clr_W = 1'b1;
        end else if (stall) begin
            en_PC = 1'b0;
            en_D  = 1'b0;
            clr_E = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    localparam int MULT = 5;
    localparam int DIV  = 10;
`ifdef MD_UNIT_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        IntReq;
    logic [4:0]  rs_D, rt_D, A3_E, A3_M;
    logic [1:0]  tuse_rs, tuse_rt, tnew_E, tnew_M;
    logic        md_use_D, md_start_E, md_is_div_E;
    logic        en_PC, en_D, clr_D, clr_E, clr_M, clr_W, md_busy;
    logic [31:0] stall_cnt;

    pipe_hazard_ctrl #(.MULT_CYC(MULT), .DIV_CYC(DIV)) dut (
        .clk(clk), .reset(reset), .IntReq(IntReq),
        .rs_D(rs_D), .rt_D(rt_D), .tuse_rs(tuse_rs), .tuse_rt(tuse_rt),
        .A3_E(A3_E), .A3_M(A3_M), .tnew_E(tnew_E), .tnew_M(tnew_M),
        .md_use_D(md_use_D), .md_start_E(md_start_E), .md_is_div_E(md_is_div_E),
        .en_PC(en_PC), .en_D(en_D), .clr_D(clr_D), .clr_E(clr_E),
        .clr_M(clr_M), .clr_W(clr_W), .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          en_pc, en_d, cd, ce, cm, cw, busy;
        logic [31:0] scnt;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          busy_left = 0;
    logic [31:0] m_stalls = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit reg_hazard(input logic [4:0] r, input logic [1:0] tuse);
        return (r != 0) && (((r == A3_E) && (int'(tnew_E) > int'(tuse))) ||
                            ((r == A3_M) && (int'(tnew_M) > int'(tuse))));
    endfunction

    // Expected response for the inputs currently applied, then advance the reference state.
    task automatic step();
        exp_t e;
        bit   md_h, stl;
        md_h = MD_EN && md_use_D && ((busy_left > 0) || md_start_E);
        stl  = (reg_hazard(rs_D, tuse_rs) || reg_hazard(rt_D, tuse_rt) || md_h) && !IntReq;
        e.busy = (busy_left > 0);
        e.scnt = m_stalls;
        if (reset || IntReq) begin
            e.en_pc = 1; e.en_d = 1; e.cd = 1; e.ce = 1; e.cm = 1; e.cw = 1;
        end else if (stl) begin
            e.en_pc = 0; e.en_d = 0; e.cd = 0; e.ce = 1; e.cm = 0; e.cw = 0;
        end else begin
            e.en_pc = 1; e.en_d = 1; e.cd = 0; e.ce = 0; e.cm = 0; e.cw = 0;
        end
        exp_q.push_back(e);
        if (reset) begin
            busy_left = 0;
            m_stalls  = 32'd0;
        end else begin
            if (stl && m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 1;
            if (MD_EN && md_start_E && !IntReq) busy_left = md_is_div_E ? DIV : MULT;
            else if (busy_left > 0) busy_left = busy_left - 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 0; IntReq = 0;
        rs_D = 0; rt_D = 0; tuse_rs = 3; tuse_rt = 3;
        A3_E = 0; A3_M = 0; tnew_E = 0; tnew_M = 0;
        md_use_D = 0; md_start_E = 0; md_is_div_E = 0;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("en_PC",     32'(en_PC),   32'(e.en_pc));
            chk("en_D",      32'(en_D),    32'(e.en_d));
            chk("clr_D",     32'(clr_D),   32'(e.cd));
            chk("clr_E",     32'(clr_E),   32'(e.ce));
            chk("clr_M",     32'(clr_M),   32'(e.cm));
            chk("clr_W",     32'(clr_W),   32'(e.cw));
            chk("md_busy",   32'(md_busy), 32'(e.busy));
            chk("stall_cnt", stall_cnt,    e.scnt);
        end
    end

    initial begin
        idle();
        reset = 1;
        @(posedge clk);
        #1;
        step(); step();
        idle(); step();

        // Forwarding hazard from E, then a register-zero non-hazard
        rs_D = 5; tuse_rs = 0; A3_E = 5; tnew_E = 1;
        step(); step();
        idle(); rs_D = 0; A3_E = 0; tnew_E = 2; tuse_rs = 0;
        step();

        // Divide with a dependent md instruction waiting in D
        idle(); md_start_E = 1; md_is_div_E = 1; md_use_D = 1;
        step();
        md_start_E = 0; md_is_div_E = 0;
        repeat (12) step();

        // Interrupt overriding an rt hazard
        idle(); rt_D = 7; tuse_rt = 0; A3_M = 7; tnew_M = 2; IntReq = 1;
        step();
        IntReq = 0; step();

        // Multiply start swallowed by interrupt; then interrupt mid-multiply
        idle(); md_start_E = 1; IntReq = 1; step();
        idle(); step(); step();
        md_start_E = 1; step();
        idle(); step();
        IntReq = 1; step();
        IntReq = 0; repeat (5) step();

        // Reset in the middle of a divide
        idle(); md_start_E = 1; md_is_div_E = 1; md_use_D = 1; step();
        md_start_E = 0; step(); step();
        reset = 1; step();
        reset = 0; step(); step();

        // Reload while busy
        idle(); md_start_E = 1; md_is_div_E = 1; step();
        idle(); step(); step();
        md_start_E = 1; step();
        idle(); repeat (7) step();

        repeat (3000) begin
            reset       = ($urandom_range(0, 99) == 0);
            IntReq      = ($urandom_range(0, 9) == 0);
            rs_D        = 5'($urandom_range(0, 3));
            rt_D        = 5'($urandom_range(0, 3));
            A3_E        = 5'($urandom_range(0, 3));
            A3_M        = 5'($urandom_range(0, 3));
            tuse_rs     = 2'($urandom_range(0, 3));
            tuse_rt     = 2'($urandom_range(0, 3));
            tnew_E      = 2'($urandom_range(0, 3));
            tnew_M      = 2'($urandom_range(0, 3));
            md_use_D    = ($urandom_range(0, 2) == 0);
            md_start_E  = ($urandom_range(0, 7) == 0);
            md_is_div_E = 1'($urandom_range(0, 1));
            step();
        end

        idle();
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual %0d required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
